// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: opcode decode, stage sequencing, ALUOp and datapath controls.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state instead of being executed as a NOP.
module multicycle_main_control (
    input  logic       CLK,
    input  logic       Reset_L,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [3:0] State,
    output logic       Exception
);
    // state  | meaning
    // FETCH  | read instruction at PC, PC+4 (waits on MemReady)
    // DECODE | latch opcode, compute branch target
    // MEMADR | compute lw/sw effective address
    // MEMRD  | load data read (waits on MemReady)
    // MEMWB  | write MDR to rt
    // MEMWR  | store data write (waits on MemReady)
    // EXEC   | R-type ALU operation
    // ALUWB  | write ALUOut to rd
    // BRANCH | beq compare, conditional PC load
    // JUMP   | load jump target into PC
    // IEXEC  | immediate ALU operation
    // IWB    | write ALUOut to rt
    // TRAP   | illegal opcode, held until reset
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11,
        TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_LSW    = 4'b0000;
    localparam logic [3:0] ALU_BRANCH = 4'b0001;
    localparam logic [3:0] ALU_RTYPE  = 4'b0010;
    localparam logic [3:0] ALU_ADDI   = 4'b0100;
    localparam logic [3:0] ALU_ADDIU  = 4'b0101;
    localparam logic [3:0] ALU_ANDI   = 4'b0110;
    localparam logic [3:0] ALU_ORI    = 4'b0111;

    state_t     state;
    state_t     next_state;
    logic [5:0] op_reg;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state  <= FETCH;
            op_reg <= 6'b000000;
        end else begin
            state <= next_state;
            if (state == DECODE)
                op_reg <= Opcode;
        end
    end

    always_comb begin
        next_state  = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_LSW;
        Exception   = 1'b0;

        case (state)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                next_state = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                // Decode from the live IR field; op_reg only becomes valid next cycle.
                case (Opcode)
                    OP_LW, OP_SW:                         next_state = MEMADR;
                    OP_RTYPE:                             next_state = EXEC;
                    OP_BEQ:                               next_state = BRANCH;
                    OP_J:                                 next_state = JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI:   next_state = IEXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:                              next_state = TRAP;
`else
                    default:                              next_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (op_reg == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                next_state = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_RTYPE;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_BRANCH;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = IWB;
                case (op_reg)
                    OP_ADDI:  ALUOp = ALU_ADDI;
                    OP_ADDIU: ALUOp = ALU_ADDIU;
                    OP_ANDI:  ALUOp = ALU_ANDI;
                    OP_ORI:   ALUOp = ALU_ORI;
                    default:  ALUOp = ALU_LSW;
                endcase
            end
            IWB: begin
                RegWrite = 1'b1;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                Exception  = 1'b1;
                next_state = TRAP;
`else
                next_state = FETCH;
`endif
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: per-cycle vector table through a scoreboard, plus async reset cases.
module tb_multicycle_main_control;
    logic       clk = 1'b0;
    logic       reset_l;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, exception;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_main_control dut (
        .CLK(clk), .Reset_L(reset_l), .Opcode(opcode), .MemReady(mem_ready),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord),
        .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
        .MemtoReg(mem_to_reg), .RegDst(reg_dst), .RegWrite(reg_write),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PCSource(pc_source),
        .ALUOp(alu_op), .State(state), .Exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [17:0] ctl;
        logic       exc;
    } exp_t;

    typedef struct {
        string      tag;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic [17:0] ctl;
        logic       exc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic logic [17:0] ctl(input logic pcw, pcwc, iord_e, mr, mw, irw, m2r, rd, rw, asa,
                                        input logic [1:0] asb, pcs, input logic [3:0] aop);
        return {pcw, pcwc, iord_e, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop};
    endfunction

    logic [17:0] c_fetch_w, c_fetch_r, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
    logic [17:0] c_exec, c_aluwb, c_branch, c_jump, c_iwb, c_zero;

    task automatic check_out();
        exp_t        e;
        logic [17:0] act;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty got=0 entries required>=1");
            return;
        end
        e   = sb.pop_front();
        act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};
        n_cmp++;
        if (state !== e.st) begin
            n_err++;
            $display("FAIL %s state got=%0d required=%0d", e.tag, state, e.st);
        end
        n_cmp++;
        if (act !== e.ctl) begin
            n_err++;
            $display("FAIL %s controls got=%b required=%b", e.tag, act, e.ctl);
        end
        n_cmp++;
        if (exception !== e.exc) begin
            n_err++;
            $display("FAIL %s exception got=%b required=%b", e.tag, exception, e.exc);
        end
    endtask

    task automatic apply(input string tag, input logic [5:0] op, input logic mr,
                         input logic [3:0] st, input logic [17:0] c, input logic exc);
        exp_t e;
        @(negedge clk);
        opcode    = op;
        mem_ready = mr;
        e.tag = tag; e.st = st; e.ctl = c; e.exc = exc;
        sb.push_back(e);
        #1;
        check_out();
    endtask

    task automatic add(input string tag, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [17:0] c, input logic exc);
        vec_t v;
        v.tag = tag; v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.exc = exc;
        tbl.push_back(v);
    endtask

    // Called just after a negedge: drops reset mid-cycle and checks FETCH outputs before any clock edge.
    task automatic async_reset_check(input string tag);
        exp_t e;
        #2;
        mem_ready = 1'b0;
        reset_l   = 1'b0;
        #1;
        e.tag = tag; e.st = 4'd0; e.ctl = c_fetch_w; e.exc = 1'b0;
        sb.push_back(e);
        check_out();
        @(negedge clk);
        reset_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        c_fetch_w = ctl(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0000);
        c_fetch_r = ctl(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 4'b0000);
        c_decode  = ctl(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0000);
        c_memadr  = ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0000);
        c_memrd   = ctl(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0000);
        c_memwb   = ctl(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 4'b0000);
        c_memwr   = ctl(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000);
        c_exec    = ctl(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 4'b0010);
        c_aluwb   = ctl(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 4'b0000);
        c_branch  = ctl(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0001);
        c_jump    = ctl(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'b0000);
        c_iwb     = ctl(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 4'b0000);
        c_zero    = 18'd0;

        add("r_fetch",   6'b000000, 1, 4'd0,  c_fetch_r, 0);
        add("r_decode",  6'b000000, 1, 4'd1,  c_decode,  0);
        add("r_exec",    6'b000000, 1, 4'd6,  c_exec,    0);
        add("r_aluwb",   6'b000000, 0, 4'd7,  c_aluwb,   0);
        add("lw_fstall", 6'b100011, 0, 4'd0,  c_fetch_w, 0);
        add("lw_fetch",  6'b100011, 1, 4'd0,  c_fetch_r, 0);
        add("lw_decode", 6'b100011, 1, 4'd1,  c_decode,  0);
        add("lw_memadr", 6'b100011, 0, 4'd2,  c_memadr,  0);
        add("lw_rd_st1", 6'b100011, 0, 4'd3,  c_memrd,   0);
        add("lw_rd_st2", 6'b100011, 0, 4'd3,  c_memrd,   0);
        add("lw_rd_ok",  6'b100011, 1, 4'd3,  c_memrd,   0);
        add("lw_memwb",  6'b100011, 1, 4'd4,  c_memwb,   0);
        add("sw_fetch",  6'b101011, 1, 4'd0,  c_fetch_r, 0);
        add("sw_decode", 6'b101011, 1, 4'd1,  c_decode,  0);
        add("sw_memadr", 6'b101011, 1, 4'd2,  c_memadr,  0);
        add("sw_wr_st",  6'b101011, 0, 4'd5,  c_memwr,   0);
        add("sw_wr_ok",  6'b101011, 1, 4'd5,  c_memwr,   0);
        add("beq_fetch", 6'b000100, 1, 4'd0,  c_fetch_r, 0);
        add("beq_dec",   6'b000100, 1, 4'd1,  c_decode,  0);
        add("beq_br",    6'b000100, 1, 4'd8,  c_branch,  0);
        add("j_fetch",   6'b000010, 1, 4'd0,  c_fetch_r, 0);
        add("j_dec",     6'b000010, 1, 4'd1,  c_decode,  0);
        add("j_jump",    6'b000010, 1, 4'd9,  c_jump,    0);
        add("addi_f",    6'b001000, 1, 4'd0,  c_fetch_r, 0);
        add("addi_d",    6'b001000, 1, 4'd1,  c_decode,  0);
        add("addi_x",    6'b001000, 1, 4'd10, ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0100), 0);
        add("addi_wb",   6'b001000, 1, 4'd11, c_iwb,     0);
        add("addiu_f",   6'b001001, 1, 4'd0,  c_fetch_r, 0);
        add("addiu_d",   6'b001001, 1, 4'd1,  c_decode,  0);
        add("addiu_x",   6'b001001, 1, 4'd10, ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0101), 0);
        add("addiu_wb",  6'b001001, 1, 4'd11, c_iwb,     0);
        add("andi_f",    6'b001100, 1, 4'd0,  c_fetch_r, 0);
        add("andi_d",    6'b001100, 1, 4'd1,  c_decode,  0);
        add("andi_x",    6'b001100, 1, 4'd10, ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0110), 0);
        add("andi_wb",   6'b001100, 1, 4'd11, c_iwb,     0);
        add("ori_f",     6'b001101, 1, 4'd0,  c_fetch_r, 0);
        add("ori_d",     6'b001101, 1, 4'd1,  c_decode,  0);
        add("ori_x",     6'b000000, 1, 4'd10, ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0111), 0);
        add("ori_wb",    6'b000000, 1, 4'd11, c_iwb,     0);
        add("ill_f",     6'b111111, 1, 4'd0,  c_fetch_r, 0);
        add("ill_d",     6'b111111, 1, 4'd1,  c_decode,  0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++)
            add("ill_trap", 6'b000000, logic'(i[0]), 4'd15, c_zero, 1);
`else
        add("ill_nop",   6'b000000, 0, 4'd0,  c_fetch_w, 0);
`endif

        opcode    = 6'b000000;
        mem_ready = 1'b0;
        reset_l   = 1'b0;
        #1;
        e.tag = "reset"; e.st = 4'd0; e.ctl = c_fetch_w; e.exc = 1'b0;
        sb.push_back(e);
        check_out();
        repeat (2) @(negedge clk);
        reset_l = 1'b1;

        foreach (tbl[i])
            apply(tbl[i].tag, tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].ctl, tbl[i].exc);

`ifdef ILLEGAL_TRAP_EN
        async_reset_check("trap_reset");
`endif

        apply("rr_fetch",  6'b000000, 1, 4'd0, c_fetch_r, 0);
        apply("rr_decode", 6'b000000, 1, 4'd1, c_decode,  0);
        apply("rr_exec",   6'b000000, 1, 4'd6, c_exec,    0);
        async_reset_check("reset_mid_exec");

        apply("rs_fetch",  6'b101011, 1, 4'd0, c_fetch_r, 0);
        apply("rs_decode", 6'b101011, 1, 4'd1, c_decode,  0);
        apply("rs_memadr", 6'b101011, 1, 4'd2, c_memadr,  0);
        apply("rs_wr_st",  6'b101011, 0, 4'd5, c_memwr,   0);
        async_reset_check("reset_mid_memwr");

        apply("post_fetch", 6'b000100, 1, 4'd0, c_fetch_r, 0);
        apply("post_dec",   6'b000100, 1, 4'd1, c_decode,  0);
        apply("post_br",    6'b000100, 1, 4'd8, c_branch,  0);
        apply("post_back",  6'b000100, 0, 4'd0, c_fetch_w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
